fir_tap_feeder: RTL and testbench
=================================

# fir_tap_feeder

Producer side of the MAC tap interface: loads the FIR coefficient set, builds the sliding sample window, and presents `tp_w`/`H` with a window-valid strobe to the MAC unit. It sits between the sample source (valid/ready stream) and `mac_u`. It owns all sequencing: coefficient load, window priming, steady-state shifting, clear, and reload.

## Interface
- `DATA_WIDTH`, 13, sample and coefficient width (signed).
- `TAPS`, 8, window length; must be ≥ 2.
- `CLK`  in  1  clock, rising edge.
- `RST_n`  in  1  asynchronous, active-low reset.
- `COEF_V`  in  1  coefficient word valid.
- `COEF_IN`  in  DATA_WIDTH signed  coefficient word, written in order index 0..TAPS-1.
- `RELOAD`  in  1  single-cycle request to restart coefficient load.
- `CLR`  in  1  single-cycle request to zero the window and re-prime.
- `DIN`  in  DATA_WIDTH signed  input sample.
- `VIN`  in  1  sample valid.
- `RDY_IN`  out  1  sample ready; a sample is accepted when `VIN && RDY_IN`.
- `tp_w`  out  [DATA_WIDTH-1:0] x TAPS signed  window; `tp_w[0]` newest, `tp_w[TAPS-1]` oldest.
- `H`  out  [DATA_WIDTH-1:0] x TAPS signed  coefficients; `H[i]` pairs with `tp_w[i]`.
- `VWIN`  out  1  window valid, single-cycle strobe per new full window.
- `COEF_LOADED`  out  1  high in PRIME and RUN.

## Operation
- States: LOAD, PRIME, RUN.
- LOAD:
  - Entered from reset or `RELOAD`; `RDY_IN`=0.
  - Each cycle with `COEF_V`=1: `H[cidx] <= COEF_IN`, then `cidx++`.
  - On the write with `cidx==TAPS-1`: go to PRIME, zero `tp_w`, zero the fill count.
  - `H` entries not yet rewritten keep their previous values.
- PRIME: `RDY_IN`=1.
  - Each accept: shift (`tp_w[i] <= tp_w[i-1]`, `tp_w[0] <= DIN`), `fill++`.
  - The accept that makes `fill==TAPS` goes to RUN and asserts `VWIN` in the next cycle.
- RUN: `RDY_IN`=1. Each accept shifts the window and asserts `VWIN` in the next cycle. No accept means no shift and `VWIN`=0.
- `COEF_V` is ignored outside LOAD.
- Priority each cycle: `RELOAD` > `CLR` > sample accept.
  - `RELOAD` (any state, including mid-load): next state LOAD, `cidx`=0, `VWIN`=0, window unchanged.
  - `CLR` in PRIME/RUN: zero `tp_w`, `fill`=0, next state PRIME, `VWIN`=0. `CLR` in LOAD is ignored.
- `RDY_IN` = (state∈{PRIME,RUN}) && !`RELOAD` && !`CLR`. This is the only combinational path from inputs to outputs. A sample presented alongside `RELOAD`/`CLR` is not accepted.
- No arithmetic. Widths pass through unchanged. `fill` saturates at TAPS. `cidx` and `fill` are $clog2(TAPS)+1 bits.

## Timing
- Reset values: state LOAD, `tp_w` all 0, `H` all 0, `VWIN` 0, `COEF_LOADED` 0, `RDY_IN` 0, `cidx` 0, `fill` 0.
- Reset mid-operation aborts immediately, with no partial outputs afterwards.
- Accept in cycle n: updated `tp_w` and `VWIN`=1 are visible in cycle n+1 (1-cycle latency), and `tp_w` is stable until the next accept.
- Sustained throughput is one sample per cycle, with no MAC backpressure.
- Last coefficient write in cycle n: `COEF_LOADED`=1 and `RDY_IN`=1 in cycle n+1.
- `H` never changes while in RUN.

## Structure
- Shared `dsp_pkg` holds:
  - the state enum `feeder_state_t` {LOAD, PRIME, RUN};
  - the default `DATA_WIDTH`/`TAPS` constants, shared with `mac_u`.
- Sub-module `tap_delay_line`: TAPS-deep shift register with shift-enable and sync clear.
- Top level holds the FSM, the counters, and the `H` register file.

## Test plan
- Reset, write `H` = 1..8 with `COEF_V` held 8 cycles → `COEF_LOADED` rises the cycle after the 8th write; `H`=[1..8]; `VWIN` stays 0.
- After load, feed `DIN` = 10,20,…,80 back-to-back → `VWIN` first pulses the cycle after 80 is accepted, with `tp_w`=[80,70,…,10]. Feeding 90 next → `tp_w`=[90,…,20] and `VWIN` pulses again.
- In RUN, gap `VIN` low for 3 cycles → `tp_w` holds and `VWIN`=0 throughout. Sample -4096 (min signed 13-bit) passes through unchanged.
- `CLR` together with `VIN`=1, `DIN`=55 → 55 not accepted, `tp_w` all 0, PRIME. Eight further accepts are needed before the next `VWIN`.
- `RELOAD` after 3 of 8 coefficient writes, then 8 fresh writes 100..107 → `H`=[100..107]. No sample is accepted until the load completes.
- Assert `RST_n`=0 in RUN mid-stream → all outputs return to reset values immediately, with no `VWIN` pulse after release until a full reload and prime.

Source files
------------

// File: rtl/fir_tap_feeder_pkg.sv
// Shared DSP definitions for the FIR tap feeder and the MAC unit it drives.
package dsp_pkg;

  localparam int DATA_WIDTH_DEF = 13;
  localparam int TAPS_DEF       = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/fir_tap_feeder_if.sv
// Tap interface between the sample/coefficient sources, the feeder and the MAC.
interface fir_tap_feeder_if #(
  parameter int DATA_WIDTH = dsp_pkg::DATA_WIDTH_DEF,
  parameter int TAPS       = dsp_pkg::TAPS_DEF
);
  logic                                COEF_V;
  logic [DATA_WIDTH-1:0]               COEF_IN;
  logic                                RELOAD;
  logic                                CLR;
  logic [DATA_WIDTH-1:0]               DIN;
  logic                                VIN;
  logic                                RDY_IN;
  logic [TAPS-1:0][DATA_WIDTH-1:0]     tp_w;
  logic [TAPS-1:0][DATA_WIDTH-1:0]     H;
  logic                                VWIN;
  logic                                COEF_LOADED;

  modport master (
    input  COEF_V, COEF_IN, RELOAD, CLR, DIN, VIN,
    output RDY_IN, tp_w, H, VWIN, COEF_LOADED
  );

  modport slave (
    output COEF_V, COEF_IN, RELOAD, CLR, DIN, VIN,
    input  RDY_IN, tp_w, H, VWIN, COEF_LOADED
  );
endinterface

// File: rtl/fir_tap_feeder_tap_delay_line.sv
// TAPS-deep sample shift register; taps_o[0] is the newest sample.
module tap_delay_line #(
  parameter int DATA_WIDTH = dsp_pkg::DATA_WIDTH_DEF,
  parameter int TAPS       = dsp_pkg::TAPS_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            shift_en,
  input  logic                            clr,
  input  logic [DATA_WIDTH-1:0]           din,
  output logic [TAPS-1:0][DATA_WIDTH-1:0] taps_o
);

  logic [TAPS-1:0][DATA_WIDTH-1:0] taps_q, taps_d;

  always_comb begin
    taps_d = taps_q;
    if (clr) begin
      taps_d = '0;
    end else if (shift_en) begin
      taps_d[0] = din;
      for (int i = 1; i < TAPS; i++) begin
        taps_d[i] = taps_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) taps_q <= '0;
    else        taps_q <= taps_d;
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/fir_tap_feeder.sv
// FIR tap feeder: coefficient load, window priming and steady-state shifting
// towards the MAC unit.
//
// state | meaning
// LOAD  | collecting TAPS coefficient words, samples refused
// PRIME | coefficients valid, filling the window after load or clear
// RUN   | window full, every accepted sample yields a VWIN strobe
module fir_tap_feeder
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TAPS       = TAPS_DEF
) (
  input logic              CLK,
  input logic              RST_n,
  fir_tap_feeder_if.master bus
);

  localparam int CW = $clog2(TAPS) + 1;
  localparam int IW = $clog2(TAPS);

  feeder_state_t                   state_q, state_d;
  logic [CW-1:0]                   cidx_q, cidx_d;
  logic [CW-1:0]                   fill_q, fill_d;
  logic [TAPS-1:0][DATA_WIDTH-1:0] h_q, h_d;
  logic                            vwin_q, vwin_d;
  logic                            rdy;
  logic                            accept;
  logic                            shift_en;
  logic                            win_clr;

  // Only combinational input-to-output path: RELOAD/CLR pre-empt sample accept.
  assign rdy    = (state_q != LOAD) && !bus.RELOAD && !bus.CLR;
  assign accept = bus.VIN && rdy;

  always_comb begin
    state_d  = state_q;
    cidx_d   = cidx_q;
    fill_d   = fill_q;
    h_d      = h_q;
    vwin_d   = 1'b0;
    shift_en = 1'b0;
    win_clr  = 1'b0;

    if (bus.RELOAD) begin
      state_d = LOAD;
      cidx_d  = '0;
    end else if (bus.CLR && (state_q != LOAD)) begin
      state_d = PRIME;
      fill_d  = '0;
      win_clr = 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.COEF_V) begin
            h_d[cidx_q[IW-1:0]] = bus.COEF_IN;
            cidx_d              = cidx_q + CW'(1);
            if (cidx_q == CW'(TAPS - 1)) begin
              state_d = PRIME;
              fill_d  = '0;
              win_clr = 1'b1;
            end
          end
        end
        PRIME: begin
          if (accept) begin
            shift_en = 1'b1;
            if (fill_q != CW'(TAPS)) fill_d = fill_q + CW'(1);
            if (fill_q == CW'(TAPS - 1)) begin
              state_d = RUN;
              vwin_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            shift_en = 1'b1;
            vwin_d   = 1'b1;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= LOAD;
      cidx_q  <= '0;
      fill_q  <= '0;
      h_q     <= '0;
      vwin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cidx_q  <= cidx_d;
      fill_q  <= fill_d;
      h_q     <= h_d;
      vwin_q  <= vwin_d;
    end
  end

  tap_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAPS       (TAPS)
  ) u_delay (
    .clk      (CLK),
    .rst_n    (RST_n),
    .shift_en (shift_en),
    .clr      (win_clr),
    .din      (bus.DIN),
    .taps_o   (bus.tp_w)
  );

  assign bus.RDY_IN      = rdy;
  assign bus.H           = h_q;
  assign bus.VWIN        = vwin_q;
  assign bus.COEF_LOADED = (state_q != LOAD);

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Directed self-checking bench for fir_tap_feeder (DATA_WIDTH 13, TAPS 8).
module tb_fir_tap_feeder;

  localparam int DW   = 13;
  localparam int TAPS = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  fir_tap_feeder_if #(.DATA_WIDTH(DW), .TAPS(TAPS)) bus ();

  fir_tap_feeder #(.DATA_WIDTH(DW), .TAPS(TAPS)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int tap(input int i);
    return int'($signed(bus.tp_w[i]));
  endfunction

  function automatic int coef(input int i);
    return int'($signed(bus.H[i]));
  endfunction

  task automatic load_coefs(input int base);
    for (int k = 0; k < TAPS; k++) begin
      bus.COEF_V  = 1'b1;
      bus.COEF_IN = DW'(base + k);
      tick();
      chk("load_vwin", int'(bus.VWIN), 0);
      chk("load_loaded", int'(bus.COEF_LOADED), (k == TAPS - 1) ? 1 : 0);
    end
    bus.COEF_V = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n       = 1'b0;
    bus.COEF_V  = 1'b0;
    bus.COEF_IN = '0;
    bus.RELOAD  = 1'b0;
    bus.CLR     = 1'b0;
    bus.DIN     = '0;
    bus.VIN     = 1'b0;

    #23;
    chk("rst_rdy", int'(bus.RDY_IN), 0);
    chk("rst_loaded", int'(bus.COEF_LOADED), 0);
    chk("rst_vwin", int'(bus.VWIN), 0);
    chk("rst_h0", coef(0), 0);
    chk("rst_tp7", tap(7), 0);
    rst_n = 1'b1;
    tick();

    // coefficients 1..8
    load_coefs(1);
    chk("ld_rdy", int'(bus.RDY_IN), 1);
    for (int i = 0; i < TAPS; i++) chk("ld_h", coef(i), i + 1);

    // prime with 10..80
    for (int k = 0; k < TAPS; k++) begin
      bus.VIN = 1'b1;
      bus.DIN = DW'((k + 1) * 10);
      tick();
      chk("prime_vwin", int'(bus.VWIN), (k == TAPS - 1) ? 1 : 0);
    end
    for (int i = 0; i < TAPS; i++) chk("prime_tp", tap(i), 80 - 10 * i);

    bus.DIN = DW'(90);
    tick();
    chk("run_vwin", int'(bus.VWIN), 1);
    chk("run_tp0", tap(0), 90);
    chk("run_tp7", tap(7), 20);

    bus.VIN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gap_vwin", int'(bus.VWIN), 0);
      chk("gap_tp0", tap(0), 90);
      chk("gap_tp7", tap(7), 20);
    end

    bus.VIN = 1'b1;
    bus.DIN = DW'(-4096);
    tick();
    chk("min_vwin", int'(bus.VWIN), 1);
    chk("min_tp0", tap(0), -4096);
    chk("min_tp1", tap(1), 90);
    chk("run_h_hold", coef(7), 8);

    // CLR with a sample present: sample refused, window zeroed
    bus.CLR = 1'b1;
    bus.DIN = DW'(55);
    #1;
    chk("clr_rdy_comb", int'(bus.RDY_IN), 0);
    tick();
    bus.CLR = 1'b0;
    chk("clr_vwin", int'(bus.VWIN), 0);
    chk("clr_loaded", int'(bus.COEF_LOADED), 1);
    for (int i = 0; i < TAPS; i++) chk("clr_tp", tap(i), 0);
    for (int k = 0; k < TAPS; k++) begin
      bus.DIN = DW'(k + 1);
      tick();
      chk("reprime_vwin", int'(bus.VWIN), (k == TAPS - 1) ? 1 : 0);
    end
    chk("reprime_tp0", tap(0), 8);
    chk("reprime_tp7", tap(7), 1);

    // RELOAD, partial load, RELOAD again, full load while samples offered
    bus.VIN    = 1'b0;
    bus.RELOAD = 1'b1;
    #1;
    chk("rl_rdy_comb", int'(bus.RDY_IN), 0);
    tick();
    bus.RELOAD = 1'b0;
    chk("rl_loaded", int'(bus.COEF_LOADED), 0);
    chk("rl_vwin", int'(bus.VWIN), 0);
    chk("rl_tp0", tap(0), 8);
    bus.VIN = 1'b1;
    bus.DIN = DW'(999);
    for (int k = 0; k < 3; k++) begin
      bus.COEF_V  = 1'b1;
      bus.COEF_IN = DW'(200 + k);
      tick();
      chk("part_rdy", int'(bus.RDY_IN), 0);
    end
    chk("part_h2", coef(2), 202);
    chk("part_h3", coef(3), 4);
    bus.COEF_V = 1'b0;
    bus.RELOAD = 1'b1;
    tick();
    bus.RELOAD = 1'b0;
    load_coefs(100);
    for (int i = 0; i < TAPS; i++) chk("rl_h", coef(i), 100 + i);
    for (int i = 0; i < TAPS; i++) chk("rl_tp", tap(i), 0);

    // prime, then async reset mid-stream
    for (int k = 0; k < TAPS; k++) begin
      bus.DIN = DW'(k + 300);
      tick();
    end
    chk("pre_rst_vwin", int'(bus.VWIN), 1);
    bus.DIN = DW'(400);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vwin", int'(bus.VWIN), 0);
    chk("arst_rdy", int'(bus.RDY_IN), 0);
    chk("arst_loaded", int'(bus.COEF_LOADED), 0);
    chk("arst_tp0", tap(0), 0);
    chk("arst_h0", coef(0), 0);
    #4;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("post_rst_vwin", int'(bus.VWIN), 0);
      chk("post_rst_rdy", int'(bus.RDY_IN), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
